// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM responder with configurable wait states,
// a one-cycle ready pulse and address/op error reporting.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        addr_error
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  state_t                r_state, w_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx;
  logic [31:0]           r_wdata, r_rdata;
  logic                  r_write, r_err;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic                  w_req, w_err, w_accept, w_rd_ok;
  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == IDLE) & w_req;
  assign w_err    = (addr[1:0] != 2'b00) | ((addr >> (ADDR_WIDTH + 2)) != '0) | (mem_read & mem_write);
  // With zero latency the read happens on the accepting edge, so use live inputs in IDLE
  assign w_idx    = (r_state == IDLE) ? addr[ADDR_WIDTH+1:2] : r_idx;
  assign w_rd_ok  = (r_state == IDLE) ? (mem_read & ~w_err) : (~r_write & ~r_err);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_nxt     = (LATENCY == 0) ? RESP : WAIT;
        w_cnt_nxt = LAT_M1;
      end
      WAIT: begin
        w_nxt     = (r_cnt == 4'd0) ? RESP : WAIT;
        w_cnt_nxt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx;
        r_wdata <= wdata;
        r_write <= mem_write;
        r_err   <= w_err;
      end
      if (w_nxt == RESP && w_rd_ok) r_rdata <= r_mem[w_idx];
    end
  // Write commits on the edge leaving RESP; an async reset forces IDLE first, discarding it
  always_ff @(posedge clk)
    if (r_state == RESP && r_write && !r_err) r_mem[r_idx] <= r_wdata;
  assign rdata      = r_rdata;
  assign ready      = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign addr_error = ready & r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder.
module tb_mem_responder;
  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready, busy, addr_error;
  logic        m0_read = 1'b0, m0_write = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic [31:0] rd0;
  logic        rdy0, busy0, err0;
  int          n_chk = 0, n_pass = 0;
  mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .addr_error(addr_error)
  );
  mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_read(m0_read), .mem_write(m0_write),
    .addr(a0), .wdata(d0), .rdata(rd0), .ready(rdy0), .busy(busy0), .addr_error(err0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Issue one request on the LATENCY=2 DUT; inputs are scrambled while busy
  task automatic do_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic ee, input logic [31:0] er);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    chk({tag, " c0 busy"}, 32'(busy), 32'd0);
    step;
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'h14; wdata = 32'hDEADBEEF;
    chk({tag, " c1 busy"}, 32'(busy), 32'd1);
    chk({tag, " c1 ready"}, 32'(ready), 32'd0);
    step;
    chk({tag, " c2 busy"}, 32'(busy), 32'd1);
    chk({tag, " c2 ready"}, 32'(ready), 32'd0);
    step;
    chk({tag, " c3 ready"}, 32'(ready), 32'd1);
    chk({tag, " c3 busy"}, 32'(busy), 32'd1);
    chk({tag, " c3 err"}, 32'(addr_error), 32'(ee));
    chk({tag, " c3 rdata"}, rdata, er);
    step;
    chk({tag, " c4 ready"}, 32'(ready), 32'd0);
    chk({tag, " c4 busy"}, 32'(busy), 32'd0);
  endtask
  initial begin
    #1;
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(addr_error), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    step; step;
    reset = 1'b0;
    do_req("wr10", 1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 1'b0, 32'h0);
    do_req("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEBABE);
    do_req("rd13 misalign", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'hCAFEBABE);
    do_req("rd400 range", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'hCAFEBABE);
    do_req("rd10 again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEBABE);
    do_req("wr20 zero", 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'hCAFEBABE);
    do_req("rdwr20 both", 1'b1, 1'b1, 32'h20, 32'h1234, 1'b1, 32'hCAFEBABE);
    do_req("rd20 prior", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    do_req("rd10 prerst", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEBABE);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h55AA55AA;
    step;
    mem_write = 1'b0;
    chk("midrst wait busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ready", 32'(ready), 32'd0);
    chk("midrst err", 32'(addr_error), 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("midrst no ready", 32'(ready), 32'd0);
    end
    reset = 1'b0;
    step;
    do_req("rd20 postrst", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
    do_req("wr3fc", 1'b0, 1'b1, 32'h3FC, 32'hFFFFFFFF, 1'b0, 32'h0);
    do_req("wr0", 1'b0, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0);
    do_req("rd3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hFFFFFFFF);
    do_req("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1);
    for (int i = 0; i < 2; i++) begin
      m0_write = 1'b1; a0 = (i == 0) ? 32'h10 : 32'h14; d0 = (i == 0) ? 32'h11111111 : 32'h22222222;
      step;
      m0_write = 1'b0;
      chk("l0 wr ready", 32'(rdy0), 32'd1);
      chk("l0 wr err", 32'(err0), 32'd0);
      step;
      chk("l0 wr idle", 32'(busy0), 32'd0);
    end
    m0_read = 1'b1; a0 = 32'h10;
    step;
    a0 = 32'h14;
    chk("l0 c1 ready", 32'(rdy0), 32'd1);
    chk("l0 c1 busy", 32'(busy0), 32'd1);
    chk("l0 c1 rdata", rd0, 32'h11111111);
    step;
    chk("l0 c2 ready", 32'(rdy0), 32'd0);
    chk("l0 c2 busy", 32'(busy0), 32'd0);
    chk("l0 c2 rdata", rd0, 32'h11111111);
    step;
    m0_read = 1'b0;
    chk("l0 c3 ready", 32'(rdy0), 32'd1);
    chk("l0 c3 busy", 32'(busy0), 32'd1);
    chk("l0 c3 rdata", rd0, 32'h22222222);
    step;
    chk("l0 c4 ready", 32'(rdy0), 32'd0);
    chk("l0 c4 busy", 32'(busy0), 32'd0);
    step;
    chk("l0 c5 ready", 32'(rdy0), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle CPU's memory interface. It services the control unit's MemRead/MemWrite requests, addressed by the IorD-selected address, against an internal word-addressed RAM. Access latency is configurable through wait states. Completion is signalled with a one-cycle ready pulse, so the control FSM can stall on it.

Parameters:
ADDR_WIDTH, 8, word-index bits; RAM depth = 2**ADDR_WIDTH words of 32 bits; valid byte range 0 .. 4*2**ADDR_WIDTH-1
LATENCY, 2, wait cycles between request acceptance and response (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  read request (level)
mem_write  input  1  write request (level)
addr  input  32  byte address
wdata  input  32  write data
rdata  output  32  read data; valid with ready on a successful read; held until the next successful read
ready  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
addr_error  output  1  pulses with ready when the request was rejected

Behaviour:
- Reset: state=IDLE, wait counter=0, rdata=0, ready=0, busy=0, addr_error=0. RAM contents are unaffected by reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - At a clock edge with mem_read|mem_write high: latch addr, wdata, op and error flag.
  - Go to WAIT with counter=LATENCY-1, or to RESP if LATENCY=0.
- WAIT: counter decrements each cycle; at counter==0 go to RESP.
- RESP:
  - ready=1 for exactly this cycle, then IDLE.
  - Successful read: rdata is registered on the edge entering RESP, so it is stable during the ready cycle.
  - Successful write: RAM updated on the edge leaving RESP.
- Latency: request seen in cycle N gives ready high in cycle N+LATENCY+1.
- Inputs are sampled only in IDLE. Changes to mem_read, mem_write, addr or wdata while busy are ignored.
- Requests that are still high when the block returns to IDLE start a new transaction. The requester must drop the request in the ready cycle to avoid a repeat. There is no idle cycle between back-to-back transactions beyond the IDLE cycle itself.
- Error conditions, latched at acceptance:
  - addr[1:0]!=0 (misaligned)
  - addr[31:ADDR_WIDTH+2]!=0 (out of range)
  - mem_read and mem_write both high
- On error: full latency is still observed, and ready pulses together with addr_error. No RAM write occurs, and rdata is unchanged.
- Word index = addr[ADDR_WIDTH+1:2].
- Reset mid-transaction: abort immediately. A pending write is discarded and no ready is produced; all outputs go to their reset values.
- Write then read of the same address: the read returns the new data, because the write commits before the next transaction is accepted.

Test Plan:
- LATENCY=2:
  - Write addr=0x10, wdata=0xCAFEBABE, request in cycle 0 -> busy high cycles 1-3, ready only in cycle 3, addr_error=0.
  - Then read 0x10 -> ready three cycles after the request, rdata=0xCAFEBABE.
- Read addr=0x13 (misaligned) and addr=0x400 (out of range, ADDR_WIDTH=8):
  - Each gives ready+addr_error after LATENCY+1 cycles.
  - rdata keeps its previous value; a later read of 0x10 is still 0xCAFEBABE.
- mem_read=mem_write=1, addr=0x20, wdata=0x1234 -> addr_error pulse, and a subsequent read of 0x20 returns its prior content (write it with 0x0 beforehand).
- Write 0x20=0x55AA55AA, then assert reset in the WAIT cycle -> outputs return to 0 with no ready pulse; a subsequent read of 0x20 returns 0x0.
- LATENCY=0 build: read held high for 4 cycles -> ready every second cycle (accept, RESP, accept, ...), busy toggling. Changing addr while busy has no effect on the returned data.
- Address wrap: write the last word 0x3FC=0xFFFFFFFF and word 0 =0x1 -> reads return the respective values with no aliasing.
